uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receive channel: deserializes the asynchronous line into BYTESIZES-bit words and presents them on a valid/ready output handshake. Runs on the oversampled tick clock clock_out, which runs at OVERSAMPLING x BAUDRATE and comes from the baud-rate generator. Frame format: 1 start bit (0), BYTESIZES data bits LSB first, optional parity bit, 1 stop bit (1). Also flags framing, parity and overrun errors.

Parameters:
BYTESIZES, 8, data bits per frame (5..9)
OVERSAMPLING, 16, clock_out cycles per bit; even, >= 4
PARITY_EN, 0, 1 = parity bit expected after the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0

Ports:
clock_out  input  1  oversampled tick clock; all flops on its rising edge
nreset  input  1  asynchronous active-low reset
sdata  input  1  serial line in; asynchronous to clock_out, idles high
ready  input  1  consumer accepts data on any edge where valid && ready
data  output  BYTESIZES  received word; data[0] = first bit received
valid  output  1  data and error flags are valid
frame_error  output  1  stop bit of the held word was sampled 0
parity_error  output  1  parity mismatch on the held word
overrun  output  1  sticky: an unconsumed word was overwritten
busy  output  1  high in every state except IDLE

Behaviour:
- Reset is nreset, asynchronous, active-low. Clock is clock_out.
- Reset values: data=0, valid=0, frame_error=0, parity_error=0, overrun=0, busy=0, state=IDLE, counters=0.
- Both synchronizer flops reset to 1, so reset never produces a false start.
- Synchronizer: sdata passes through 2 flops; the FSM sees only the synchronized value rxs.
- Counters: cnt is $clog2(OVERSAMPLING) bits wide; bitidx is $clog2(BYTESIZES+1) bits wide; shift register is BYTESIZES bits wide.
- State IDLE:
  - If rxs==0: go to START, cnt=0.
- State START:
  - cnt increments every cycle.
  - At cnt==OVERSAMPLING/2-1 (mid start bit), sample rxs.
  - rxs==0: go to DATA, cnt=0, bitidx=0.
  - rxs==1 (glitch or false start): go to IDLE. No flag is raised.
- State DATA:
  - At cnt==OVERSAMPLING-1: cnt=0, shift rxs into the MSB (right shift), bitidx++.
  - After the BYTESIZES-th sample: go to PARITY if PARITY_EN=1, otherwise go to STOP.
- State PARITY:
  - At cnt==OVERSAMPLING-1, capture the parity bit.
  - perr = (^shift ^ pbit) != PARITY_ODD.
  - Go to STOP.
- State STOP:
  - At cnt==OVERSAMPLING-1, sample the stop bit. This is the completion edge.
  - On that edge: load data<=shift, frame_error<=~rxs, parity_error<=perr (0 when PARITY_EN=0), valid<=1.
  - rxs==1: go to IDLE, which re-arms mid stop bit so back-to-back frames are supported.
  - rxs==0: go to BREAK.
- State BREAK:
  - Wait for rxs==1, then go to IDLE. A held-low line yields exactly one word.
- Latency: completion edge = IDLE detection edge + OVERSAMPLING/2 + (BYTESIZES+PARITY_EN+1)*OVERSAMPLING cycles. The synchronizer adds 2 more cycles from the raw line.
- Handshake:
  - valid stays high until an edge with valid&&ready; on that edge valid<=0 and overrun<=0.
  - data and the error flags are stable while valid=1, except on an overrun.
- Completion with valid=1 and ready=0: new word and flags overwrite the held ones, valid stays 1, overrun<=1.
- Completion coinciding with valid&&ready: the old word is consumed, the new word is loaded, valid stays 1, overrun<=0.
- Reset mid-frame: the partial frame is discarded and all outputs return to their reset values.

Test Plan:
- 8N1, OVERSAMPLING=16: drive 0xA5, ready=1 -> data=0xA5, valid=1 for one cycle, all error flags 0; valid rises 152 cycles after the IDLE detection edge.
- Start glitch (line low 4 cycles, then high) -> returns to IDLE, busy drops, valid stays 0, no flags; a following 0x3C frame is received correctly.
- Stop bit forced 0 on frame 0x55, then line held low 100 bit times -> one word 0x55 with frame_error=1; no further words until the line returns high and a new start bit arrives.
- PARITY_EN=1, PARITY_ODD=0: 0x07 with parity bit 1 -> parity_error=0; same word with parity bit 0 -> parity_error=1.
- ready=0: receive 0x11 then 0x22 back-to-back -> data=0x22, overrun=1; a ready pulse -> valid=0, overrun=0. Repeat with ready asserted exactly on the second completion edge -> data=0x22, overrun=0.
- nreset asserted mid data bit 4 of a frame -> outputs return to reset values immediately; after release the next full frame 0xF0 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receive channel: oversampled deserializer with a valid/ready output
// handshake and framing, parity and overrun flags.
module uart_rx #(
  parameter int unsigned BYTESIZES    = 8,
  parameter int unsigned OVERSAMPLING = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 clock_out,
  input  logic                 nreset,
  input  logic                 sdata,
  input  logic                 ready,
  output logic [BYTESIZES-1:0] data,
  output logic                 valid,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(OVERSAMPLING);
  localparam int unsigned BW = $clog2(BYTESIZES + 1);

  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLING / 2 - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLING - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(BYTESIZES - 1);
  localparam logic          HAS_PAR  = (PARITY_EN != 0);
  localparam logic          ODD_PAR  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic                 sync_q;
  logic                 rxs;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bitidx_q, bitidx_d;
  logic [BYTESIZES-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 done;
  logic [BYTESIZES-1:0] data_d;
  logic                 valid_d;
  logic                 frame_error_d;
  logic                 parity_error_d;
  logic                 overrun_d;
  logic                 busy_d;

  // Two-flop synchronizer; both stages reset high so reset never looks like a start bit
  always_ff @(posedge clock_out or negedge nreset) begin
    if (!nreset) begin
      sync_q <= 1'b1;
      rxs    <= 1'b1;
    end else begin
      sync_q <= sdata;
      rxs    <= sync_q;
    end
  end

  // FSM state register
  always_ff @(posedge clock_out or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, bit timing, shift register and output handshake
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bitidx_d       = bitidx_q;
    shift_d        = shift_q;
    perr_d         = perr_q;
    done           = 1'b0;
    data_d         = data;
    valid_d        = valid;
    frame_error_d  = frame_error;
    parity_error_d = parity_error;
    overrun_d      = overrun;

    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      // Re-check the line at the middle of the start bit to reject glitches
      S_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d    = '0;
          bitidx_d = '0;
          perr_d   = 1'b0;
          state_d  = rxs ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_END) begin
          cnt_d    = '0;
          shift_d  = {rxs, shift_q[BYTESIZES-1:1]};
          bitidx_d = bitidx_q + BW'(1);
          if (bitidx_q == IDX_LAST) begin
            state_d = HAS_PAR ? S_PARITY : S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_PARITY: begin
        if (cnt_q == CNT_END) begin
          cnt_d   = '0;
          perr_d  = ((^shift_q) ^ rxs) != ODD_PAR;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Stop bit sampled mid-bit; returning to IDLE here allows back-to-back frames
      S_STOP: begin
        if (cnt_q == CNT_END) begin
          cnt_d   = '0;
          done    = 1'b1;
          state_d = rxs ? S_IDLE : S_BREAK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Held-low line: wait for idle so a break yields a single word
      S_BREAK: begin
        if (rxs) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (done) begin
      data_d         = shift_q;
      frame_error_d  = ~rxs;
      parity_error_d = HAS_PAR & perr_q;
      valid_d        = 1'b1;
      overrun_d      = valid & ~ready;
    end else if (valid && ready) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // Datapath and registered outputs
  always_ff @(posedge clock_out or negedge nreset) begin
    if (!nreset) begin
      cnt_q        <= '0;
      bitidx_q     <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      data         <= '0;
      valid        <= 1'b0;
      frame_error  <= 1'b0;
      parity_error <= 1'b0;
      overrun      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      bitidx_q     <= bitidx_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      data         <= data_d;
      valid        <= valid_d;
      frame_error  <= frame_error_d;
      parity_error <= parity_error_d;
      overrun      <= overrun_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: 8N1 instance plus an 8E1 instance for parity.
module tb_uart_rx;

  localparam int OS = 16;

  logic       clock_out = 1'b0;
  logic       nreset;
  logic       sdata;
  logic       sdata_p;
  logic       ready;
  logic       ready_p;
  logic [7:0] data;
  logic       valid, frame_error, parity_error, overrun, busy;
  logic [7:0] data_p;
  logic       valid_p, frame_error_p, parity_error_p, overrun_p, busy_p;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_start = 0;
  int n0      = 0;

  // Monitor of the 8N1 instance, sampled on the falling edge
  logic       v_prev    = 1'b0;
  int         n_rise    = 0;
  int         n_vcyc    = 0;
  int         rise_cyc  = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_fe   = 1'b0;
  logic       last_pe   = 1'b0;
  logic       last_ov   = 1'b0;

  uart_rx #(.BYTESIZES(8), .OVERSAMPLING(OS), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
    .clock_out    (clock_out),
    .nreset       (nreset),
    .sdata        (sdata),
    .ready        (ready),
    .data         (data),
    .valid        (valid),
    .frame_error  (frame_error),
    .parity_error (parity_error),
    .overrun      (overrun),
    .busy         (busy)
  );

  uart_rx #(.BYTESIZES(8), .OVERSAMPLING(OS), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_par (
    .clock_out    (clock_out),
    .nreset       (nreset),
    .sdata        (sdata_p),
    .ready        (ready_p),
    .data         (data_p),
    .valid        (valid_p),
    .frame_error  (frame_error_p),
    .parity_error (parity_error_p),
    .overrun      (overrun_p),
    .busy         (busy_p)
  );

  always #5 clock_out = ~clock_out;

  always @(posedge clock_out) cyc <= cyc + 1;

  always @(negedge clock_out) begin
    v_prev <= valid;
    if (valid && !v_prev) begin
      n_rise   <= n_rise + 1;
      rise_cyc <= cyc;
    end
    if (valid) begin
      n_vcyc    <= n_vcyc + 1;
      last_data <= data;
      last_fe   <= frame_error;
      last_pe   <= parity_error;
      last_ov   <= overrun;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock_out);
    #1;
  endtask

  task automatic drive_bit(input int which, input logic v);
    if (which == 0) sdata = v;
    else            sdata_p = v;
    tick(OS);
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input logic par_en,
                            input logic pbit, input logic stop);
    t_start = cyc;
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
    if (par_en) drive_bit(which, pbit);
    drive_bit(which, stop);
  endtask

  initial begin
    int v0;
    logic [7:0] w;

    nreset  = 1'b0;
    sdata   = 1'b1;
    sdata_p = 1'b1;
    ready   = 1'b1;
    ready_p = 1'b0;
    tick(3);

    // Reset state
    check("rst_data",  32'(data), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_fe",    32'(frame_error), 32'h0);
    check("rst_pe",    32'(parity_error), 32'h0);
    check("rst_ov",    32'(overrun), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_busy_p", 32'(busy_p), 32'h0);
    nreset = 1'b1;
    tick(4);

    // 8N1 0xA5 with ready=1: one-cycle valid, 155 cycles after the raw falling edge
    n0 = n_rise;
    v0 = n_vcyc;
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    tick(4);
    check("a5_words",   32'(n_rise - n0), 32'd1);
    check("a5_vcycles", 32'(n_vcyc - v0), 32'd1);
    check("a5_data",    32'(last_data), 32'hA5);
    check("a5_fe",      32'(last_fe), 32'h0);
    check("a5_pe",      32'(last_pe), 32'h0);
    check("a5_ov",      32'(last_ov), 32'h0);
    check("a5_latency", 32'(rise_cyc - t_start), 32'd155);
    check("a5_valid_after", 32'(valid), 32'h0);

    // Start-bit glitch: 4 cycles low, rejected at mid start bit
    n0 = n_rise;
    sdata = 1'b0;
    tick(4);
    sdata = 1'b1;
    tick(2);
    check("glitch_busy_hi", 32'(busy), 32'h1);
    tick(10);
    check("glitch_busy_lo", 32'(busy), 32'h0);
    check("glitch_words",   32'(n_rise - n0), 32'd0);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    tick(4);
    check("3c_words", 32'(n_rise - n0), 32'd1);
    check("3c_data",  32'(last_data), 32'h3C);
    check("3c_fe",    32'(last_fe), 32'h0);

    // Stop bit 0 then line held low 100 bit times: exactly one word, frame error
    n0 = n_rise;
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
    tick(100 * OS);
    check("brk_busy",  32'(busy), 32'h1);
    check("brk_words", 32'(n_rise - n0), 32'd1);
    check("brk_data",  32'(last_data), 32'h55);
    check("brk_fe",    32'(last_fe), 32'h1);
    sdata = 1'b1;
    tick(20);
    check("brk_idle",   32'(busy), 32'h0);
    check("brk_words2", 32'(n_rise - n0), 32'd1);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
    tick(4);
    check("81_words", 32'(n_rise - n0), 32'd2);
    check("81_data",  32'(last_data), 32'h81);
    check("81_fe",    32'(last_fe), 32'h0);

    // Even parity: 0x07 has three ones, so parity bit 1 is correct, 0 is wrong
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    tick(4);
    check("par_ok_valid", 32'(valid_p), 32'h1);
    check("par_ok_data",  32'(data_p), 32'h07);
    check("par_ok_pe",    32'(parity_error_p), 32'h0);
    check("par_ok_fe",    32'(frame_error_p), 32'h0);
    ready_p = 1'b1;
    tick(1);
    ready_p = 1'b0;
    check("par_ok_taken", 32'(valid_p), 32'h0);
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    tick(4);
    check("par_bad_valid", 32'(valid_p), 32'h1);
    check("par_bad_data",  32'(data_p), 32'h07);
    check("par_bad_pe",    32'(parity_error_p), 32'h1);
    ready_p = 1'b1;
    tick(1);
    ready_p = 1'b0;
    check("par_bad_taken", 32'(valid_p), 32'h0);
    check("par_bad_ov",    32'(overrun_p), 32'h0);

    // Overrun: two back-to-back words with ready low
    ready = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    check("ov1_valid", 32'(valid), 32'h1);
    check("ov1_data",  32'(data), 32'h11);
    check("ov1_ov",    32'(overrun), 32'h0);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
    tick(2);
    check("ov2_valid", 32'(valid), 32'h1);
    check("ov2_data",  32'(data), 32'h22);
    check("ov2_ov",    32'(overrun), 32'h1);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check("ov_pop_valid", 32'(valid), 32'h0);
    check("ov_pop_ov",    32'(overrun), 32'h0);

    // Ready asserted exactly on the second completion edge: consume and reload
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    check("co1_data", 32'(data), 32'h11);
    w = 8'h22;
    t_start = cyc;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(0, w[i]);
    sdata = 1'b1;
    tick(10);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check("co_edge", 32'(cyc - t_start), 32'd155);
    check("co_valid", 32'(valid), 32'h1);
    check("co_data",  32'(data), 32'h22);
    check("co_ov",    32'(overrun), 32'h0);
    tick(5);
    check("co_hold", 32'(valid), 32'h1);

    // Reset in the middle of data bit 4 while a word is still held
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
    sdata = 1'b0;
    tick(OS / 2);
    check("mid_busy", 32'(busy), 32'h1);
    nreset = 1'b0;
    #1;
    check("mr_data",  32'(data), 32'h0);
    check("mr_valid", 32'(valid), 32'h0);
    check("mr_fe",    32'(frame_error), 32'h0);
    check("mr_ov",    32'(overrun), 32'h0);
    check("mr_busy",  32'(busy), 32'h0);
    sdata = 1'b1;
    tick(3);
    nreset = 1'b1;
    tick(3);
    check("mr_idle", 32'(busy), 32'h0);
    ready = 1'b1;
    n0 = n_rise;
    send_frame(0, 8'hF0, 1'b0, 1'b0, 1'b1);
    tick(4);
    check("f0_words", 32'(n_rise - n0), 32'd1);
    check("f0_data",  32'(last_data), 32'hF0);
    check("f0_fe",    32'(last_fe), 32'h0);
    check("f0_valid", 32'(valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
